// File: rtl/pix_buff_unpacker.sv
// ---------------------------------------------------------------------------
// pix_buff_unpacker
//
// Drains the PIX_BUFF pixel FIFO on its read side and turns each packed word
// into PIX_PER_WORD pixels (LSB pixel first). The pixels leave as a
// valid/ready stream with start-of-frame and end-of-line markers derived from
// free-running raster counters that only advance on an accepted pixel.
//
// Ports
//   clk            single clock for FIFO read side and pixel stream
//   rst            synchronous, active-high reset
//   fifo_rd_en     FIFO pop request (combinational, gated by rst)
//   fifo_rd_data   FIFO read data, valid RD_LATENCY cycles after fifo_rd_en
//   fifo_rd_empty  FIFO empty flag
//   pix_data       current pixel (registered)
//   pix_valid      pix_data valid (registered)
//   pix_ready      downstream accepts the pixel
//   pix_sof        first pixel of a frame (col 0, row 0) (registered)
//   pix_eol        last pixel of a line (col H_ACTIVE-1) (registered)
// ---------------------------------------------------------------------------
module pix_buff_unpacker #(
  parameter int DATA_WIDTH = 240,
  parameter int PIX_WIDTH  = 24,
  parameter int RD_LATENCY = 2,
  parameter int H_ACTIVE   = 640,
  parameter int V_ACTIVE   = 480
) (
  input  logic                  clk,
  input  logic                  rst,
  output logic                  fifo_rd_en,
  input  logic [DATA_WIDTH-1:0] fifo_rd_data,
  input  logic                  fifo_rd_empty,
  output logic [PIX_WIDTH-1:0]  pix_data,
  output logic                  pix_valid,
  input  logic                  pix_ready,
  output logic                  pix_sof,
  output logic                  pix_eol
);

  localparam int PIX_PER_WORD = DATA_WIDTH / PIX_WIDTH;
  localparam int IDX_W = (PIX_PER_WORD > 1) ? $clog2(PIX_PER_WORD) : 1;
  localparam int COL_W = (H_ACTIVE > 1) ? $clog2(H_ACTIVE) : 1;
  localparam int ROW_W = (V_ACTIVE > 1) ? $clog2(V_ACTIVE) : 1;

  // Two-entry word buffer: buf0 is always the head (word being unpacked).
  logic [DATA_WIDTH-1:0] buf0_r, buf1_r, buf0_n, buf1_n;
  logic [1:0]            occ_r, occ_n;
  // One bit per cycle of read latency; the top bit marks data on the bus now.
  logic [RD_LATENCY-1:0] vld_sr_r, vld_sr_n;
  logic [IDX_W-1:0]      idx_r, idx_n;
  logic [COL_W-1:0]      col_r, col_n;
  logic [ROW_W-1:0]      row_r, row_n;

  logic [PIX_WIDTH-1:0]  pix_data_r, pix_data_n;
  logic                  pix_valid_r, pix_valid_n;
  logic                  pix_sof_r, pix_sof_n;
  logic                  pix_eol_r, pix_eol_n;

  logic [2:0]            inflight_s, outstanding_s;
  logic                  rd_en_s, fire_s, pop_s, cap_s;
  logic [PIX_PER_WORD-1:0][PIX_WIDTH-1:0] head_pix_s;

  assign fifo_rd_en = rd_en_s;
  assign pix_data   = pix_data_r;
  assign pix_valid  = pix_valid_r;
  assign pix_sof    = pix_sof_r;
  assign pix_eol    = pix_eol_r;

  // Read issue: count buffered plus in-flight words, never exceed two.
  always_comb begin
    inflight_s = 3'd0;
    for (int k = 0; k < RD_LATENCY; k++) begin
      inflight_s = inflight_s + {2'b00, vld_sr_r[k]};
    end
    outstanding_s = {1'b0, occ_r} + inflight_s;
    if (!rst && !fifo_rd_empty && (outstanding_s < 3'd2)) begin
      rd_en_s = 1'b1;
    end else begin
      rd_en_s = 1'b0;
    end
    vld_sr_n[0] = rd_en_s;
    for (int k = 1; k < RD_LATENCY; k++) begin
      vld_sr_n[k] = vld_sr_r[k-1];
    end
  end

  assign cap_s  = vld_sr_r[RD_LATENCY-1];
  assign fire_s = pix_valid_r && pix_ready;
  assign pop_s  = fire_s && (idx_r == IDX_W'(PIX_PER_WORD - 1));

  // Word buffer update: pop and capture in the same cycle keep occ unchanged.
  always_comb begin
    buf0_n = buf0_r;
    buf1_n = buf1_r;
    occ_n  = occ_r;
    case ({pop_s, cap_s})
      2'b11: begin
        if (occ_r == 2'd2) begin
          buf0_n = buf1_r;
          buf1_n = fifo_rd_data;
        end else begin
          buf0_n = fifo_rd_data;
        end
      end
      2'b10: begin
        buf0_n = buf1_r;
        occ_n  = occ_r - 2'd1;
      end
      2'b01: begin
        if (occ_r == 2'd0) begin
          buf0_n = fifo_rd_data;
        end else begin
          buf1_n = fifo_rd_data;
        end
        occ_n = occ_r + 2'd1;
      end
      default: begin
        occ_n = occ_r;
      end
    endcase
  end

  // Pixel index and raster counters, advancing only on an accepted pixel.
  always_comb begin
    idx_n = idx_r;
    col_n = col_r;
    row_n = row_r;
    if (fire_s) begin
      if (idx_r == IDX_W'(PIX_PER_WORD - 1)) begin
        idx_n = {IDX_W{1'b0}};
      end else begin
        idx_n = idx_r + IDX_W'(1);
      end
      if (col_r == COL_W'(H_ACTIVE - 1)) begin
        col_n = {COL_W{1'b0}};
        if (row_r == ROW_W'(V_ACTIVE - 1)) begin
          row_n = {ROW_W{1'b0}};
        end else begin
          row_n = row_r + ROW_W'(1);
        end
      end else begin
        col_n = col_r + COL_W'(1);
      end
    end else begin
      idx_n = idx_r;
    end
  end

  // Output decode from next state so the stream outputs come straight from flops.
  always_comb begin
    head_pix_s  = buf0_n;
    pix_valid_n = (occ_n != 2'd0);
    pix_data_n  = head_pix_s[idx_n];
    pix_sof_n   = pix_valid_n && (col_n == {COL_W{1'b0}}) && (row_n == {ROW_W{1'b0}});
    pix_eol_n   = pix_valid_n && (col_n == COL_W'(H_ACTIVE - 1));
  end

  // State and output registers; reset also drops words still in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      buf0_r      <= {DATA_WIDTH{1'b0}};
      buf1_r      <= {DATA_WIDTH{1'b0}};
      occ_r       <= 2'd0;
      vld_sr_r    <= {RD_LATENCY{1'b0}};
      idx_r       <= {IDX_W{1'b0}};
      col_r       <= {COL_W{1'b0}};
      row_r       <= {ROW_W{1'b0}};
      pix_data_r  <= {PIX_WIDTH{1'b0}};
      pix_valid_r <= 1'b0;
      pix_sof_r   <= 1'b0;
      pix_eol_r   <= 1'b0;
    end else begin
      buf0_r      <= buf0_n;
      buf1_r      <= buf1_n;
      occ_r       <= occ_n;
      vld_sr_r    <= vld_sr_n;
      idx_r       <= idx_n;
      col_r       <= col_n;
      row_r       <= row_n;
      pix_data_r  <= pix_data_n;
      pix_valid_r <= pix_valid_n;
      pix_sof_r   <= pix_sof_n;
      pix_eol_r   <= pix_eol_n;
    end
  end

endmodule

// File: tb/tb_pix_buff_unpacker.sv
// ---------------------------------------------------------------------------
// tb_pix_buff_unpacker
//
// Four DUT builds, each fed by its own FIFO model with a matching read
// latency:
//   0: defaults (640x480, latency 2)   1: 4x2 raster, latency 2
//   2: latency 1                       3: latency 3
// Word k carries pixel i = {k[11:0], i[11:0]}. A negedge monitor logs every
// accepted pixel and tracks stall stability and buffer-occupancy violations.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_pix_buff_unpacker;

  typedef struct {
    logic [23:0] d;
    logic        sof;
    logic        eol;
    int          cyc;
  } ev_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic [3:0]   rd_en, empty, valid, sof, eol, rdy;
  logic [23:0]  pd [4];
  logic [239:0] rdd [4];
  logic [239:0] mem [4][64];
  logic [5:0]   wr_p [4];
  logic [5:0]   rd_p [4];
  logic [239:0] pipe [4][3];

  ev_t q0[$], q1[$], q2[$], q3[$];
  int  n_assert = 0;
  int  n_fail   = 0;
  int  cyc      = 0;
  int  issued [4];
  int  fired  [4];
  int  rd_viol [4];
  int  stall_viol [4];
  logic        pv_prev [4];
  logic        pr_prev [4];
  logic [23:0] pd_prev [4];
  logic        ps_prev [4];
  logic        pe_prev [4];

  assign rdd[0] = pipe[0][1];
  assign rdd[1] = pipe[1][1];
  assign rdd[2] = pipe[2][0];
  assign rdd[3] = pipe[3][2];

  pix_buff_unpacker u0 (.clk(clk), .rst(rst), .fifo_rd_en(rd_en[0]), .fifo_rd_data(rdd[0]),
    .fifo_rd_empty(empty[0]), .pix_data(pd[0]), .pix_valid(valid[0]), .pix_ready(rdy[0]),
    .pix_sof(sof[0]), .pix_eol(eol[0]));
  pix_buff_unpacker #(.H_ACTIVE(4), .V_ACTIVE(2)) u1 (.clk(clk), .rst(rst), .fifo_rd_en(rd_en[1]),
    .fifo_rd_data(rdd[1]), .fifo_rd_empty(empty[1]), .pix_data(pd[1]), .pix_valid(valid[1]),
    .pix_ready(rdy[1]), .pix_sof(sof[1]), .pix_eol(eol[1]));
  pix_buff_unpacker #(.RD_LATENCY(1)) u2 (.clk(clk), .rst(rst), .fifo_rd_en(rd_en[2]),
    .fifo_rd_data(rdd[2]), .fifo_rd_empty(empty[2]), .pix_data(pd[2]), .pix_valid(valid[2]),
    .pix_ready(rdy[2]), .pix_sof(sof[2]), .pix_eol(eol[2]));
  pix_buff_unpacker #(.RD_LATENCY(3)) u3 (.clk(clk), .rst(rst), .fifo_rd_en(rd_en[3]),
    .fifo_rd_data(rdd[3]), .fifo_rd_empty(empty[3]), .pix_data(pd[3]), .pix_valid(valid[3]),
    .pix_ready(rdy[3]), .pix_sof(sof[3]), .pix_eol(eol[3]));

  // FIFO empty flags
  always_comb begin
    for (int i = 0; i < 4; i++) empty[i] = (wr_p[i] == rd_p[i]);
  end

  // FIFO read-side models; reset flushes, the data pipe is left stale on purpose
  always @(posedge clk) begin
    for (int i = 0; i < 4; i++) begin
      if (rst) rd_p[i] <= wr_p[i];
      else if (rd_en[i]) rd_p[i] <= rd_p[i] + 6'd1;
      pipe[i][0] <= rd_en[i] ? mem[i][rd_p[i]] : {10{24'hBADBAD}};
      pipe[i][1] <= pipe[i][0];
      pipe[i][2] <= pipe[i][1];
    end
  end

  task automatic log_ev(input int i, input ev_t e);
    case (i)
      0: q0.push_back(e);
      1: q1.push_back(e);
      2: q2.push_back(e);
      default: q3.push_back(e);
    endcase
  endtask

  // Monitor: log accepted pixels, check stall stability and occupancy bound
  always @(negedge clk) begin
    ev_t e;
    cyc++;
    for (int i = 0; i < 4; i++) begin
      if (rst) begin
        issued[i]  = 0;
        fired[i]   = 0;
        pv_prev[i] = 1'b0;
        pr_prev[i] = 1'b0;
      end else begin
        if (pv_prev[i] && !pr_prev[i] &&
            (valid[i] !== 1'b1 || pd[i] !== pd_prev[i] || sof[i] !== ps_prev[i] || eol[i] !== pe_prev[i]))
          stall_viol[i]++;
        if (rd_en[i]) begin
          if (issued[i] - fired[i] / 10 >= 2) rd_viol[i]++;
          issued[i]++;
        end
        if (valid[i] && rdy[i]) begin
          e.d = pd[i]; e.sof = sof[i]; e.eol = eol[i]; e.cyc = cyc;
          log_ev(i, e);
          fired[i]++;
        end
        pv_prev[i] = valid[i];
        pr_prev[i] = rdy[i];
        pd_prev[i] = pd[i];
        ps_prev[i] = sof[i];
        pe_prev[i] = eol[i];
      end
    end
  end

  function automatic int qsize(input int i);
    case (i)
      0: return q0.size();
      1: return q1.size();
      2: return q2.size();
      default: return q3.size();
    endcase
  endfunction

  function automatic ev_t get_ev(input int i, input int n);
    case (i)
      0: return q0[n];
      1: return q1[n];
      2: return q2[n];
      default: return q3[n];
    endcase
  endfunction

  function automatic logic [23:0] pix(input int k, input int i);
    return {k[11:0], i[11:0]};
  endfunction

  task automatic push(input int inst, input int k);
    logic [239:0] w;
    for (int i = 0; i < 10; i++) w[i*24 +: 24] = pix(k, i);
    mem[inst][wr_p[inst]] = w;
    wr_p[inst] = wr_p[inst] + 6'd1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic wait_pix(input int inst, input int n, input int budget);
    int b;
    b = 0;
    while (qsize(inst) < n && b < budget) begin
      @(posedge clk); #1;
      b++;
    end
    chk($sformatf("pix_count_inst%0d", inst), 64'(qsize(inst)), 64'(n));
  endtask

  // Watchdog
  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    ev_t e, e0;
    rdy = 4'b0000;
    for (int i = 0; i < 4; i++) begin
      wr_p[i] = 6'd0; rd_p[i] = 6'd0;
      rd_viol[i] = 0; stall_viol[i] = 0;
    end
    repeat (3) @(posedge clk);
    #1;
    // reset state
    chk("rst_valid", 64'(valid[0]), 64'd0);
    chk("rst_data",  64'(pd[0]), 64'd0);
    chk("rst_sof",   64'(sof[0]), 64'd0);
    chk("rst_eol",   64'(eol[0]), 64'd0);
    chk("rst_rd_en", 64'(rd_en[0]), 64'd0);

    // preload all instances, ready high
    rst = 1'b0;
    for (int k = 0; k < 3; k++) push(0, k);
    for (int k = 0; k < 2; k++) push(1, k);
    for (int k = 0; k < 5; k++) begin push(2, k); push(3, k); end
    rdy = 4'b1111;

    // 3 preloaded words, continuous ready
    wait_pix(0, 30, 200);
    for (int n = 0; n < 30; n++) begin
      e = get_ev(0, n);
      chk($sformatf("a_data%0d", n), 64'(e.d), 64'(pix(n / 10, n % 10)));
      chk($sformatf("a_sof%0d", n), 64'(e.sof), 64'(n == 0));
      chk($sformatf("a_eol%0d", n), 64'(e.eol), 64'd0);
    end
    e0 = get_ev(0, 0);
    e  = get_ev(0, 29);
    chk("a_no_bubble", 64'(e.cyc - e0.cyc), 64'd29);

    // 4-word stream with ready toggling every cycle
    for (int k = 3; k < 7; k++) push(0, k);
    for (int c = 0; c < 300 && qsize(0) < 70; c++) begin
      rdy[0] = ~rdy[0];
      @(posedge clk); #1;
    end
    rdy[0] = 1'b1;
    chk("b_count", 64'(qsize(0)), 64'd70);
    for (int n = 30; n < 70; n++) begin
      e = get_ev(0, n);
      chk($sformatf("b_data%0d", n), 64'(e.d), 64'(pix(3 + (n - 30) / 10, n % 10)));
      chk($sformatf("b_sof%0d", n), 64'(e.sof), 64'd0);
    end

    // small raster: eol every 4th pixel, sof every 8th
    wait_pix(1, 20, 100);
    for (int n = 0; n < 20; n++) begin
      e = get_ev(1, n);
      chk($sformatf("e_data%0d", n), 64'(e.d), 64'(pix(n / 10, n % 10)));
      chk($sformatf("e_eol%0d", n), 64'(e.eol), 64'(n % 4 == 3));
      chk($sformatf("e_sof%0d", n), 64'(e.sof), 64'(n % 8 == 0));
    end

    // latency 1 and 3 builds
    wait_pix(2, 50, 200);
    wait_pix(3, 50, 200);
    for (int n = 0; n < 50; n++) begin
      e = get_ev(2, n);
      chk($sformatf("f_l1_data%0d", n), 64'(e.d), 64'(pix(n / 10, n % 10)));
      e = get_ev(3, n);
      chk($sformatf("f_l3_data%0d", n), 64'(e.d), 64'(pix(n / 10, n % 10)));
    end
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("rd_overfill_inst%0d", i), 64'(rd_viol[i]), 64'd0);
      chk($sformatf("stall_unstable_inst%0d", i), 64'(stall_viol[i]), 64'd0);
    end

    // single word, FIFO empty, later resume; full line check on eol
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    q0.delete();
    push(0, 16);
    wait_pix(0, 10, 100);
    repeat (20) @(posedge clk);
    #1;
    chk("c_idle_valid", 64'(valid[0]), 64'd0);
    chk("c_idle_rd_en", 64'(rd_en[0]), 64'd0);
    chk("c_idle_count", 64'(qsize(0)), 64'd10);
    for (int k = 17; k < 80; k++) push(0, k);
    wait_pix(0, 640, 1500);
    for (int n = 0; n < 640; n++) begin
      e = get_ev(0, n);
      chk($sformatf("c_data%0d", n), 64'(e.d), 64'(pix(16 + n / 10, n % 10)));
      chk($sformatf("c_sof%0d", n), 64'(e.sof), 64'(n == 0));
      chk($sformatf("c_eol%0d", n), 64'(e.eol), 64'(n == 639));
    end

    // reset with two reads in flight
    rst = 1'b1;
    rdy[0] = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    for (int k = 0; k < 4; k++) push(0, 12'hF00 + k);
    #1;
    chk("d_rd_en_c0", 64'(rd_en[0]), 64'd1);
    @(posedge clk); #1;
    chk("d_rd_en_c1", 64'(rd_en[0]), 64'd1);
    @(posedge clk); #1;
    chk("d_rd_en_full", 64'(rd_en[0]), 64'd0);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("d_valid_after_rst", 64'(valid[0]), 64'd0);
    q0.delete();
    rdy[0] = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    chk("d_stale_count", 64'(qsize(0)), 64'd0);
    chk("d_stale_valid", 64'(valid[0]), 64'd0);
    push(0, 32);
    push(0, 33);
    wait_pix(0, 20, 100);
    for (int n = 0; n < 20; n++) begin
      e = get_ev(0, n);
      chk($sformatf("d_data%0d", n), 64'(e.d), 64'(pix(32 + n / 10, n % 10)));
      chk($sformatf("d_sof%0d", n), 64'(e.sof), 64'(n == 0));
    end
    chk("rd_overfill_final", 64'(rd_viol[0]), 64'd0);
    chk("stall_unstable_final", 64'(stall_viol[0]), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
